// File: rtl/gpio_cfg_serial_loader_if.sv
// Bus between housekeeping, the GPIO configuration loader and the pad serial chain.
// The master side is housekeeping plus the chain; the slave side is the loader.
// Optional readback signals exist only when GPIO_CFG_READBACK_EN is defined.
interface gpio_cfg_serial_loader_if #(
    parameter int NUM_PADS = 27,
    parameter int CFG_BITS = 13
);
    localparam int PW = $clog2(NUM_PADS);

    logic                start;
    logic                busy;
    logic                done;
    logic [PW-1:0]       cfg_addr;
    logic [CFG_BITS-1:0] cfg_data;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                serial_resetn;
`ifdef GPIO_CFG_READBACK_EN
    logic                serial_return;
    logic                rb_we;
    logic [PW-1:0]       rb_addr;
    logic [CFG_BITS-1:0] rb_data;

    modport master (
        output start, cfg_data, serial_return,
        input  busy, done, cfg_addr, serial_clock, serial_data, serial_load,
               serial_resetn, rb_we, rb_addr, rb_data
    );
    modport slave (
        input  start, cfg_data, serial_return,
        output busy, done, cfg_addr, serial_clock, serial_data, serial_load,
               serial_resetn, rb_we, rb_addr, rb_data
    );
`else
    modport master (
        output start, cfg_data,
        input  busy, done, cfg_addr, serial_clock, serial_data, serial_load,
               serial_resetn
    );
    modport slave (
        input  start, cfg_data,
        output busy, done, cfg_addr, serial_clock, serial_data, serial_load,
               serial_resetn
    );
`endif
endinterface

// File: rtl/gpio_cfg_serial_loader.sv
// GPIO pad configuration loader: fetches one CFG_BITS word per pad from the
// housekeeping register array (highest pad first), shifts it MSB-first down the
// pad serial chain and then strobes serial_load so every pad switches at once.
// Optional feature macro: GPIO_CFG_READBACK_EN captures the old chain contents
// from serial_return and writes them back one pad at a time.
// NUM_PADS must be at least 2 so the pad counter has a nonzero width.
module gpio_cfg_serial_loader #(
    parameter int NUM_PADS = 27,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    gpio_cfg_serial_loader_if.slave bus
);
    localparam int PW = $clog2(NUM_PADS);
    localparam int BW = $clog2(CFG_BITS);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(NUM_PADS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, SHIFT_LO, SHIFT_HI, LOAD, DONE
    } state_t;

    state_t              state_reg;
    logic [PW-1:0]       pad_cnt_reg;
    logic [BW-1:0]       bit_cnt_reg;
    logic [DW-1:0]       div_cnt_reg;
    logic [CFG_BITS-1:0] shift_reg;
    logic [CFG_BITS-1:0] shift_next;
    logic [PW-1:0]       cfg_addr_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                sclk_reg;
    logic                sdata_reg;
    logic                sload_reg;
    logic                sresetn_reg;

    // Word after the bit currently on the chain has been consumed.
    assign shift_next = {shift_reg[CFG_BITS-2:0], 1'b0};

`ifdef GPIO_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rb_shift_reg;
    logic [CFG_BITS-1:0] rb_shift_next;
    logic                rb_we_reg;
    logic [PW-1:0]       rb_addr_reg;
    logic [CFG_BITS-1:0] rb_data_reg;

    // The chain tail bit is taken in at the end of each high phase.
    assign rb_shift_next = {rb_shift_reg[CFG_BITS-2:0], bus.serial_return};
`endif

    // Sequencer: all outputs are registered alongside the state transitions.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            pad_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            div_cnt_reg  <= '0;
            shift_reg    <= '0;
            cfg_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            sdata_reg    <= 1'b0;
            sload_reg    <= 1'b0;
            sresetn_reg  <= 1'b0;
`ifdef GPIO_CFG_READBACK_EN
            rb_shift_reg <= '0;
            rb_we_reg    <= 1'b0;
            rb_addr_reg  <= '0;
            rb_data_reg  <= '0;
`endif
        end else begin
            sresetn_reg <= 1'b1;
            done_reg    <= 1'b0;
`ifdef GPIO_CFG_READBACK_EN
            rb_we_reg   <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        pad_cnt_reg  <= PAD_LAST;
                        cfg_addr_reg <= PAD_LAST;
                        busy_reg     <= 1'b1;
                        state_reg    <= FETCH;
                    end
                end
                FETCH: begin
                    // Register array answers one cycle after cfg_addr.
                    state_reg <= LATCH;
                end
                LATCH: begin
                    shift_reg   <= bus.cfg_data;
                    sdata_reg   <= bus.cfg_data[CFG_BITS-1];
                    bit_cnt_reg <= BIT_LAST;
                    div_cnt_reg <= DIV_LAST;
                    state_reg   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_cnt_reg != '0) begin
                        div_cnt_reg <= div_cnt_reg - 1'b1;
                    end else begin
                        div_cnt_reg <= DIV_LAST;
                        sclk_reg    <= 1'b1;
                        state_reg   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt_reg != '0) begin
                        div_cnt_reg <= div_cnt_reg - 1'b1;
                    end else begin
                        // Falling edge: data may change together with the clock
                        // dropping because the chain samples on the rising edge.
                        sclk_reg    <= 1'b0;
                        shift_reg   <= shift_next;
                        div_cnt_reg <= DIV_LAST;
`ifdef GPIO_CFG_READBACK_EN
                        rb_shift_reg <= rb_shift_next;
                        if (bit_cnt_reg == '0) begin
                            rb_we_reg   <= 1'b1;
                            rb_addr_reg <= pad_cnt_reg;
                            rb_data_reg <= rb_shift_next;
                        end
`endif
                        if (bit_cnt_reg != '0) begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                            sdata_reg   <= shift_next[CFG_BITS-1];
                            state_reg   <= SHIFT_LO;
                        end else if (pad_cnt_reg != '0) begin
                            pad_cnt_reg  <= pad_cnt_reg - 1'b1;
                            cfg_addr_reg <= pad_cnt_reg - 1'b1;
                            state_reg    <= FETCH;
                        end else begin
                            sload_reg <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (div_cnt_reg != '0) begin
                        div_cnt_reg <= div_cnt_reg - 1'b1;
                    end else begin
                        sload_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.cfg_addr      = cfg_addr_reg;
    assign bus.serial_clock  = sclk_reg;
    assign bus.serial_data   = sdata_reg;
    assign bus.serial_load   = sload_reg;
    assign bus.serial_resetn = sresetn_reg;
`ifdef GPIO_CFG_READBACK_EN
    assign bus.rb_we         = rb_we_reg;
    assign bus.rb_addr       = rb_addr_reg;
    assign bus.rb_data       = rb_data_reg;
`endif
endmodule
